// File: rtl/exp_pkg.sv
// Shared BF16 field definitions and FSM encodings for the softmax-denominator stage.
// Pure declarations: no logic, no latency, no backpressure.
package exp_pkg;

  localparam int BF16_W     = 16;
  localparam int BF16_EXP_W = 8;
  localparam int BF16_MAN_W = 7;
  localparam int BF16_BIAS  = 127;

  localparam logic [BF16_W-1:0] BF16_ONE = 16'h3f80;
  localparam logic [BF16_W-1:0] BF16_INF = 16'h7f80;

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/bf16_to_fixed.sv
// Converts a BF16 value to unsigned Q(INT_W).(FRAC_W), flagging Inf/NaN and overrange.
// Combinational, zero latency; no backpressure.
module bf16_to_fixed
  import exp_pkg::*;
#(
  parameter int INT_W  = 12,
  parameter int FRAC_W = 16
) (
  input  logic [BF16_W-1:0]       bf16,
  output logic [INT_W+FRAC_W-1:0] val,
  output logic                    ovf
);

  localparam int W = INT_W + FRAC_W;

  logic                  sign;
  logic [BF16_EXP_W-1:0] exp_f;
  logic [W-1:0]          mant_ext;
  int                    e;
  int                    sh;

  assign sign     = bf16[BF16_W-1];
  assign exp_f    = bf16[BF16_W-2 -: BF16_EXP_W];
  assign mant_ext = {{(W-BF16_MAN_W-1){1'b0}}, 1'b1, bf16[BF16_MAN_W-1:0]};

  always_comb begin
    val = '0;
    ovf = 1'b0;
    e   = int'(exp_f) - BF16_BIAS;
    // shift that places the hidden one at weight 2^e in the fixed-point grid
    sh  = e + FRAC_W - BF16_MAN_W;
    if (sign || exp_f == '0) begin
      val = '0;
    end else if (exp_f == '1 || e >= INT_W) begin
      ovf = 1'b1;
    end else if (sh >= 0) begin
      val = mant_ext << sh;
    end else begin
      val = mant_ext >> (-sh);
    end
  end

endmodule

// File: rtl/exp_sum_accum.sv
// Accumulates BF16 exp values per in_last-delimited vector; optional BF16 sum via EXP_SUM_BF16_OUT_EN.
// Latency: in_last accepted -> out_valid 2 cycles later (3 with EXP_SUM_BF16_OUT_EN).
// Backpressure: in_ready low from in_last until the result is taken; out_valid held until out_ready.
module exp_sum_accum
  import exp_pkg::*;
#(
  parameter int INT_W  = 12,
  parameter int FRAC_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BF16_W-1:0]       in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [INT_W+FRAC_W-1:0] out_sum,
  output logic [CNT_W-1:0]        out_count,
  output logic                    out_sat,
  output logic [BF16_W-1:0]       out_bf16
);

  localparam int W = INT_W + FRAC_W;

  state_t           state, next_state;
  logic             accept, handoff;
  logic [W-1:0]     conv_val;
  logic             conv_ovf;
  logic             pipe_valid, pipe_ovf;
  logic [W-1:0]     pipe_val;
  logic [W-1:0]     acc;
  logic [W:0]       sum_ext;
  logic [CNT_W-1:0] count;
  logic             sat;

  bf16_to_fixed #(.INT_W(INT_W), .FRAC_W(FRAC_W)) u_conv (
    .bf16 (in_data),
    .val  (conv_val),
    .ovf  (conv_ovf)
  );

  assign accept  = in_valid && in_ready;
  assign handoff = out_valid && out_ready;
  assign sum_ext = {1'b0, acc} + {1'b0, pipe_val};

  always_ff @(posedge clk) begin
    if (rst) state <= ST_ACC;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_ACC:   if (accept && in_last) next_state = ST_FLUSH;
`ifdef EXP_SUM_BF16_OUT_EN
      ST_FLUSH: if (!pipe_valid) next_state = ST_ROUND;
`else
      ST_FLUSH: if (!pipe_valid) next_state = ST_DONE;
`endif
      ST_ROUND: next_state = ST_DONE;
      ST_DONE:  if (out_ready) next_state = ST_ACC;
      default:  next_state = ST_ACC;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_ACC);
    out_valid = (state == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid <= 1'b0;
      pipe_val   <= '0;
      pipe_ovf   <= 1'b0;
      acc        <= '0;
      count      <= '0;
      sat        <= 1'b0;
    end else begin
      pipe_valid <= accept;
      pipe_val   <= conv_val;
      pipe_ovf   <= conv_ovf;
      if (handoff) begin
        acc   <= '0;
        count <= '0;
        sat   <= 1'b0;
      end else begin
        if (pipe_valid) begin
          if (pipe_ovf || sum_ext[W]) begin
            acc <= '1;
            sat <= 1'b1;
          end else begin
            acc <= sum_ext[W-1:0];
          end
        end
        if (accept) begin
          if (count == '1) sat <= 1'b1;
          else             count <= count + 1'b1;
        end
      end
    end
  end

  assign out_sum   = acc;
  assign out_count = count;
  assign out_sat   = sat;

`ifdef EXP_SUM_BF16_OUT_EN
  logic [W-1:0]          norm;
  logic [BF16_MAN_W-1:0] mant;
  logic [BF16_MAN_W:0]   mant_r;
  logic                  guard, sticky;
  int                    lead, ex;
  logic [BF16_W-1:0]     bf16_rnd, bf16_q;

  always_comb begin
    lead = 0;
    for (int i = 0; i < W; i++) begin
      if (acc[i]) lead = i;
    end
    // left-justify so mantissa/guard/sticky sit at fixed positions
    norm     = acc << (W - 1 - lead);
    mant     = norm[W-2 -: BF16_MAN_W];
    guard    = norm[W-2-BF16_MAN_W];
    sticky   = |norm[W-3-BF16_MAN_W:0];
    mant_r   = {1'b0, mant} + {{BF16_MAN_W{1'b0}}, (guard && (sticky || mant[0]))};
    ex       = lead - FRAC_W + BF16_BIAS + int'(mant_r[BF16_MAN_W]);
    bf16_rnd = {1'b0, ex[BF16_EXP_W-1:0], mant_r[BF16_MAN_W-1:0]};
    if (sat)            bf16_rnd = BF16_INF;
    else if (acc == '0) bf16_rnd = '0;
  end

  always_ff @(posedge clk) begin
    if (rst)                    bf16_q <= '0;
    else if (state == ST_ROUND) bf16_q <= bf16_rnd;
  end

  assign out_bf16 = bf16_q;
`else
  assign out_bf16 = 16'h0000;
`endif

endmodule

// File: tb/tb_exp_sum_accum.sv
// Directed bench for exp_sum_accum; expectations follow EXP_SUM_BF16_OUT_EN when defined.
module tb_exp_sum_accum;

`ifdef EXP_SUM_BF16_OUT_EN
  localparam int  LAT     = 3;
  localparam bit  BF16_EN = 1'b1;
`else
  localparam int  LAT     = 2;
  localparam bit  BF16_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [27:0] out_sum;
  logic [15:0] out_count;
  logic        out_sat;
  logic [15:0] out_bf16;

  int n_checks = 0;
  int n_fail   = 0;

  exp_sum_accum dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_sat   (out_sat),
    .out_bf16  (out_bf16)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [15:0] d, input logic last);
    int guard = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_wait", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_result(input string tag, input logic [27:0] sum, input logic [15:0] cnt,
                               input logic sat, input logic [15:0] bf);
    int cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, "_lat"},   cyc, LAT);
    check({tag, "_sum"},   {4'b0, out_sum}, {4'b0, sum});
    check({tag, "_count"}, {16'b0, out_count}, {16'b0, cnt});
    check({tag, "_sat"},   {31'b0, out_sat}, {31'b0, sat});
    check({tag, "_bf16"},  {16'b0, out_bf16}, BF16_EN ? {16'b0, bf} : 32'd0);
    check({tag, "_inrdy"}, {31'b0, in_ready}, 32'd0);
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_ovld_clr"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_inrdy_back"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready",  {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_sum",       {4'b0, out_sum}, 32'd0);
    check("rst_count",     {16'b0, out_count}, 32'd0);
    check("rst_sat",       {31'b0, out_sat}, 32'd0);

    // four ones with the consumer already ready
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(16'h3f80, i == 3);
    expect_result("t1", 28'h0040000, 16'd4, 1'b0, 16'h4080);
    consume("t1");

    send(16'h3f00, 1'b0);
    send(16'h3e80, 1'b1);
    expect_result("t2", 28'h000C000, 16'd2, 1'b0, 16'h3f40);
    consume("t2");

    send(16'h3f80, 1'b0);
    send(16'h7f80, 1'b1);
    expect_result("t3", 28'hFFFFFFF, 16'd2, 1'b1, 16'h7f80);
    consume("t3");

    send(16'h3380, 1'b0);
    send(16'h0000, 1'b0);
    send(16'h8000, 1'b1);
    expect_result("t4", 28'h0000000, 16'd3, 1'b0, 16'h0000);
    consume("t4");

    // result held under backpressure, then no carry-over into next vector
    send(16'h3f80, 1'b1);
    expect_result("t5a", 28'h0010000, 16'd1, 1'b0, 16'h3f80);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("t5_hold_valid", {31'b0, out_valid}, 32'd1);
      check("t5_hold_sum",   {4'b0, out_sum}, 32'h0010000);
      check("t5_hold_inrdy", {31'b0, in_ready}, 32'd0);
    end
    consume("t5a");
    send(16'h4000, 1'b1);
    expect_result("t5b", 28'h0020000, 16'd1, 1'b0, 16'h4000);
    consume("t5b");

    // reset mid-vector discards partial state
    send(16'h3f80, 1'b0);
    send(16'h3f80, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t6_rst_count", {16'b0, out_count}, 32'd0);
    check("t6_rst_valid", {31'b0, out_valid}, 32'd0);
    check("t6_rst_inrdy", {31'b0, in_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check("t6_rst_sum", {4'b0, out_sum}, 32'd0);
    check("t6_no_out",  {31'b0, out_valid}, 32'd0);
    send(16'h3f80, 1'b1);
    expect_result("t6", 28'h0010000, 16'd1, 1'b0, 16'h3f80);
    consume("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
